// File: rtl/mult_sm5_if.sv
// Request/result bundle for the mult_sm5 sign-magnitude multiplier.
// The master drives operands and start; the slave returns the product and status.
interface mult_sm5_if #(
  parameter int WIDTH = 5
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   out;
  logic                 busy;
  logic                 done;

  modport master (output start, a, b, input out, busy, done);
  modport slave  (input start, a, b, output out, busy, done);
endinterface

// File: rtl/mult_sm5.sv
// Sequential sign-magnitude fixed-point multiplier (shift-add, one magnitude bit per clock).
// Define MULT_SM5_FAST_EN to replace the iterative loop with a single-cycle product.
module mult_sm5 #(
  parameter int WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  mult_sm5_if.slave  bus
);
  localparam int M  = WIDTH - 1;
  localparam int P  = 2 * M;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             sign_r, sign_s;
  logic [P-1:0]     acc_r, acc_s;
  logic [2*WIDTH-1:0] out_r, out_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

`ifndef MULT_SM5_FAST_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [P-1:0]     mcand_r, mcand_s;
  logic [M-1:0]     mplier_r, mplier_s;
  logic [CW-1:0]    cnt_r, cnt_s;
`endif

  // Next-state and datapath update for the control FSM.
  always_comb begin
    state_s = state_r;
    sign_s  = sign_r;
    acc_s   = acc_r;
    out_s   = out_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifndef MULT_SM5_FAST_EN
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    cnt_s    = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          sign_s = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          busy_s = 1'b1;
`ifdef MULT_SM5_FAST_EN
          acc_s   = {{M{1'b0}}, bus.a[M-1:0]} * {{M{1'b0}}, bus.b[M-1:0]};
          state_s = DONE;
`else
          mcand_s  = {{M{1'b0}}, bus.a[M-1:0]};
          mplier_s = bus.b[M-1:0];
          acc_s    = {P{1'b0}};
          cnt_s    = {CW{1'b0}};
          state_s  = RUN;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifndef MULT_SM5_FAST_EN
      RUN: begin
        if (mplier_r[0]) begin
          acc_s = acc_r + mcand_r;
        end else begin
          acc_s = acc_r;
        end
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + CNT_ONE;
        // The iteration that takes the counter to WIDTH-1 is the last one.
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
`endif
      DONE: begin
        // A zero magnitude always reports a positive sign.
        out_s   = {sign_r & (acc_r != {P{1'b0}}), 1'b0, acc_r};
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      acc_r    <= {P{1'b0}};
      out_r    <= {(2*WIDTH){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifndef MULT_SM5_FAST_EN
      mcand_r  <= {P{1'b0}};
      mplier_r <= {M{1'b0}};
      cnt_r    <= {CW{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      sign_r   <= sign_s;
      acc_r    <= acc_s;
      out_r    <= out_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifndef MULT_SM5_FAST_EN
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      cnt_r    <= cnt_s;
`endif
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule

// File: tb/tb_mult_sm5.sv
// Self-checking bench for mult_sm5: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_mult_sm5;
  localparam int W = 5;
`ifdef MULT_SM5_FAST_EN
  localparam int LAT = 1;
  localparam int RST_EDGES = 0;
`else
  localparam int LAT = W;
  localparam int RST_EDGES = 1;
`endif

  logic clk;
  logic rst;
  int   npass;
  int   ntotal;
  logic [2*W-1:0] prev;

  mult_sm5_if #(.WIDTH(W)) bus ();
  mult_sm5 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  // Reference: sign XOR, exact magnitude product, no negative zero.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ma;
    int mb;
    int p;
    logic s;
    ma = int'(a[W-2:0]);
    mb = int'(b[W-2:0]);
    p  = ma * mb;
    s  = (a[W-1] != b[W-1]) && (p != 0);
    return {s, 1'b0, 8'(p)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp);
    int got;
    int cnt;
    logic [2*W-1:0] o;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    check({name, " busy_after_start"}, 32'(bus.busy), 32'd1);
    check({name, " out_held"}, 32'(bus.out), 32'(prev));
    got = 0;
    cnt = 0;
    o = '0;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cnt++;
        if (got == 0) begin
          got = n;
          o = bus.out;
        end
      end
    end
    check({name, " latency"}, 32'(got), 32'(LAT));
    check({name, " done_pulses"}, 32'(cnt), 32'd1);
    check({name, " out"}, 32'(o), 32'(exp));
    check({name, " idle_busy"}, 32'(bus.busy), 32'd0);
    prev = exp;
  endtask

  initial begin
    vec_t tbl[8];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int d1;
    int d2;
    int cnt;
    logic [2*W-1:0] o1;
    logic [2*W-1:0] o2;

    npass = 0;
    ntotal = 0;
    prev = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

    tbl[0] = '{5'b11111, 5'b10101, 10'h04B};
    tbl[1] = '{5'b11010, 5'b01000, 10'h250};
    tbl[2] = '{5'b00110, 5'b01100, 10'h048};
    tbl[3] = '{5'b01111, 5'b01111, 10'h0E1};
    tbl[4] = '{5'b10000, 5'b00101, 10'h000};
    tbl[5] = '{5'b11111, 5'b01111, 10'h2E1};
    tbl[6] = '{5'b10000, 5'b10000, 10'h000};
    tbl[7] = '{5'b00001, 5'b10001, 10'h201};

    #12;
    check("reset out", 32'(bus.out), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);
    end

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
    end

    // start held high across two operations; operand change while busy is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 5'b00111;
    bus.b = 5'b10011;
    @(posedge clk);
    #1;
    bus.a = 5'b01101;
    bus.b = 5'b01010;
    d1 = 0;
    d2 = 0;
    cnt = 0;
    o1 = '0;
    o2 = '0;
    for (int n = 1; n <= 2 * LAT + 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cnt++;
        if (cnt == 1) begin
          d1 = n;
          o1 = bus.out;
        end else if (cnt == 2) begin
          d2 = n;
          o2 = bus.out;
        end
      end
      if (n == LAT + 1) bus.start = 1'b0;
    end
    check("held first_done", 32'(d1), 32'(LAT));
    check("held first_out", 32'(o1), 32'(model(5'b00111, 5'b10011)));
    check("held second_done", 32'(d2), 32'(2 * LAT + 1));
    check("held second_out", 32'(o2), 32'(model(5'b01101, 5'b01010)));
    check("held done_count", 32'(cnt), 32'd2);
    prev = o2;

    // Reset in the middle of an operation aborts it without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 5'b01011;
    bus.b = 5'b01101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (RST_EDGES) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("midrst out", 32'(bus.out), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < LAT + 3; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
    check("midrst no_done", 32'(cnt), 32'd0);
    check("midrst out_stays", 32'(bus.out), 32'd0);
    prev = '0;

    run_op("recover", 5'b01001, 5'b11011, model(5'b01001, 5'b11011));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
